// File: rtl/instr_seq.sv
// instr_seq: command sequencer between the SPI byte bridge and the register file.
// Decodes command bytes and issues single-cycle read/write strobes on the register bus.
// Single and burst (auto-increment) transfers are supported.
// Optional feature: define INSTR_SEQ_TIMEOUT_EN to add an idle-byte watchdog.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   frame_active          SPI chip-select asserted
//   byte_sync, data_in    1-cycle strobe with a received byte
//   data_out              byte for the bridge to shift out next
//   read, write           register bus strobes (1 cycle each, never together)
//   addr, data_write      register bus address / write data
//   data_read             combinational register read data
//   err, err_clr          sticky error flag and its clear pulse
module instr_seq #(
  parameter int unsigned             ADDR_W         = 6,
  parameter logic [ADDR_W-1:0]       MAX_ADDR       = ADDR_W'(13),
  parameter int unsigned             TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_active,
  input  logic              byte_sync,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        data_write,
  input  logic [7:0]        data_read,
  output logic              err,
  input  logic              err_clr
);

  typedef enum logic [1:0] {StCmd, StWdata, StRdata, StDiscard} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_write_q, data_write_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic              burst_q, burst_d;
  logic              inc_q, inc_d;
  logic              err_q, err_d;
  logic              err_set;

  logic [ADDR_W:0]   addr_inc;
  logic [ADDR_W-1:0] cmd_addr;
  assign addr_inc = {1'b0, addr_q} + 1'b1;
  assign cmd_addr = ADDR_W'(data_in[5:0]);

`ifdef INSTR_SEQ_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_write_d = data_write_q;
    data_out_d   = data_out_q;
    burst_d      = burst_q;
    read_d       = 1'b0;
    write_d      = 1'b0;
    inc_d        = 1'b0;
    err_set      = 1'b0;
`ifdef INSTR_SEQ_TIMEOUT_EN
    cnt_d        = '0;
`endif

    // Read data is only valid while the strobe is high; capture it then.
    if (read_q) data_out_d = data_read;

    if (!frame_active) begin
      // Frame end: back to command decode; addr/data_out hold, byte dropped.
      state_d = StCmd;
    end else begin
      if (inc_q) begin
        // Post-write increment, kept out of the write cycle so addr stays stable.
        addr_d = addr_inc[ADDR_W-1:0];
        if (addr_inc > {1'b0, MAX_ADDR}) begin
          err_set = 1'b1;
          state_d = StDiscard;
        end
      end else if (byte_sync) begin
        case (state_q)
          StCmd: begin
            burst_d = data_in[6];
            addr_d  = cmd_addr;
            if (cmd_addr > MAX_ADDR) begin
              err_set = 1'b1;
              state_d = StDiscard;
            end else if (data_in[7]) begin
              state_d = StWdata;
            end else begin
              read_d  = 1'b1;
              state_d = StRdata;
            end
          end
          StWdata: begin
            data_write_d = data_in;
            write_d      = 1'b1;
            if (burst_q) inc_d = 1'b1;
            else         state_d = StDiscard;
          end
          StRdata: begin
            if (burst_q) begin
              addr_d = addr_inc[ADDR_W-1:0];
              if (addr_inc > {1'b0, MAX_ADDR}) begin
                err_set = 1'b1;
                state_d = StDiscard;
              end else begin
                read_d = 1'b1;
              end
            end else begin
              state_d = StDiscard;
            end
          end
          default: ;
        endcase
      end

`ifdef INSTR_SEQ_TIMEOUT_EN
      if (state_q != StCmd) begin
        if (byte_sync) begin
          cnt_d = '0;
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES)) begin
          err_set = 1'b1;
          state_d = StCmd;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
    end

    // A set in the same cycle as a clear wins.
    if (err_set)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StCmd;
      addr_q       <= '0;
      data_write_q <= '0;
      data_out_q   <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      burst_q      <= 1'b0;
      inc_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_write_q <= data_write_d;
      data_out_q   <= data_out_d;
      read_q       <= read_d;
      write_q      <= write_d;
      burst_q      <= burst_d;
      inc_q        <= inc_d;
      err_q        <= err_d;
    end
  end

`ifdef INSTR_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign read       = read_q;
  assign write      = write_q;
  assign addr       = addr_q;
  assign data_write = data_write_q;
  assign data_out   = data_out_q;
  assign err        = err_q;

endmodule

// File: tb/tb_instr_seq.sv
// Directed self-checking bench for instr_seq (TIMEOUT_CYCLES=16).
module tb_instr_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_active;
  logic       byte_sync;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       read;
  logic       write;
  logic [5:0] addr;
  logic [7:0] data_write;
  logic [7:0] data_read;
  logic       err;
  logic       err_clr;

  int n_checks = 0;
  int n_fail   = 0;

  // Strobe log, filled away from the active edge.
  int         n_wr = 0;
  int         n_rd = 0;
  int         n_both = 0;
  int         n_long = 0;
  logic [5:0] wr_addr [32];
  logic [7:0] wr_data [32];
  logic       prev_rd = 1'b0;
  logic       prev_wr = 1'b0;
  int         base;

  always #5 clk = ~clk;

  // Register file model: 0x08/0x09 hold a 16-bit counter 0xBEEF.
  assign data_read = (addr == 6'h08) ? 8'hEF :
                     (addr == 6'h09) ? 8'hBE : ({2'b00, addr} ^ 8'hA5);

  instr_seq #(
    .TIMEOUT_CYCLES(16)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_active(frame_active),
    .byte_sync   (byte_sync),
    .data_in     (data_in),
    .data_out    (data_out),
    .read        (read),
    .write       (write),
    .addr        (addr),
    .data_write  (data_write),
    .data_read   (data_read),
    .err         (err),
    .err_clr     (err_clr)
  );

  always @(negedge clk) begin
    if (write) begin
      if (n_wr < 32) begin
        wr_addr[n_wr] = addr;
        wr_data[n_wr] = data_write;
      end
      n_wr++;
    end
    if (read) n_rd++;
    if (read && write) n_both++;
    if ((read && prev_rd) || (write && prev_wr)) n_long++;
    prev_rd = read;
    prev_wr = write;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    data_in   = b;
    byte_sync = 1'b1;
    @(posedge clk);
    #1;
    byte_sync = 1'b0;
    idle(4);
  endtask

  task automatic frame_start();
    @(posedge clk);
    #1;
    frame_active = 1'b1;
  endtask

  task automatic frame_end();
    @(posedge clk);
    #1;
    frame_active = 1'b0;
    idle(2);
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    frame_active = 1'b0;
    byte_sync    = 1'b0;
    data_in      = 8'h00;
    err_clr      = 1'b0;
    idle(3);
    check_eq("rst_read", read, 0);
    check_eq("rst_write", write, 0);
    check_eq("rst_addr", addr, 0);
    check_eq("rst_wdata", data_write, 0);
    check_eq("rst_dout", data_out, 0);
    check_eq("rst_err", err, 0);
    rst_n = 1'b1;
    idle(2);

    // Single write; third byte must not strobe.
    base = n_wr;
    frame_start();
    send_byte(8'h8A);
    send_byte(8'h05);
    send_byte(8'h77);
    frame_end();
    check_eq("sw_count", n_wr - base, 1);
    check_eq("sw_addr", wr_addr[base], 6'h0A);
    check_eq("sw_data", wr_data[base], 8'h05);

    // Burst write 0x03..0x06.
    base = n_wr;
    frame_start();
    send_byte(8'hC3);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    frame_end();
    check_eq("bw_count", n_wr - base, 4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("bw_addr%0d", i), wr_addr[base+i], 6'h03 + i);
      check_eq($sformatf("bw_data%0d", i), wr_data[base+i], 8'h11 * (i + 1));
    end

    // Burst read of 0x08/0x09 then 0x0A.
    base = n_rd;
    frame_start();
    send_byte(8'h48);
    check_eq("br_dout0", data_out, 8'hEF);
    send_byte(8'h00);
    check_eq("br_dout1", data_out, 8'hBE);
    send_byte(8'h00);
    check_eq("br_dout2", data_out, 8'hAF);
    frame_end();
    check_eq("br_count", n_rd - base, 3);

    // Out-of-range command.
    base = n_wr;
    frame_start();
    send_byte(8'h8E);
    send_byte(8'h99);
    frame_end();
    check_eq("oor_err", err, 1);
    check_eq("oor_nowr", n_wr - base, 0);
    pulse_clr();
    check_eq("clr_err", err, 0);

    // Burst write running off the top of the map.
    base = n_wr;
    frame_start();
    send_byte(8'hCD);
    send_byte(8'h5A);
    send_byte(8'h6B);
    frame_end();
    check_eq("ovf_count", n_wr - base, 1);
    check_eq("ovf_addr", wr_addr[base], 6'h0D);
    check_eq("ovf_data", wr_data[base], 8'h5A);
    check_eq("ovf_err", err, 1);
    pulse_clr();
    check_eq("clr_err2", err, 0);

    // Abort after a write command, then a fresh write to 0x02.
    base = n_wr;
    frame_start();
    send_byte(8'h80);
    frame_end();
    frame_start();
    send_byte(8'h82);
    send_byte(8'h01);
    frame_end();
    check_eq("abt_count", n_wr - base, 1);
    check_eq("abt_addr", wr_addr[base], 6'h02);
    check_eq("abt_data", wr_data[base], 8'h01);

    // byte_sync while frame_active=0 is dropped; next byte is a command.
    base = n_wr;
    @(posedge clk);
    #1;
    data_in   = 8'h85;
    byte_sync = 1'b1;
    @(posedge clk);
    #1;
    byte_sync = 1'b0;
    frame_start();
    send_byte(8'h01);
    check_eq("drop_addr", addr, 6'h01);
    check_eq("drop_dout", data_out, 8'hA4);
    frame_end();
    check_eq("drop_nowr", n_wr - base, 0);

    // Idle after a write command.
    base = n_wr;
    frame_start();
    send_byte(8'h81);
    idle(20);
`ifdef INSTR_SEQ_TIMEOUT_EN
    check_eq("to_err", err, 1);
    send_byte(8'h5A);
    frame_end();
    check_eq("to_nowr", n_wr - base, 0);
`else
    check_eq("to_noerr", err, 0);
    send_byte(8'h5A);
    frame_end();
    check_eq("to_count", n_wr - base, 1);
    check_eq("to_data", wr_data[base], 8'h5A);
`endif

    check_eq("strobe_both", n_both, 0);
    check_eq("strobe_long", n_long, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
